// File: rtl/rob_pkg.sv
// Reorder buffer shared types and sizing.
// Imported by rob_core, its interface, and rename/execute blocks.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;
  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [31:0]       pc;
    logic [AREG_W-1:0] rd;
    logic              rd_write;
    logic [PREG_W-1:0] p_old;
    logic [PREG_W-1:0] p_new;
  } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// ROB bundle: rename alloc, execute completion, flush, commit, free.
// master = rename/execute/commit consumer side, slave = rob_core.
interface rob_if
  import rob_pkg::*;
#(
  parameter int TAG_W = rob_pkg::ROB_TAG_W
);

  logic              rn2rob_valid;
  logic [31:0]       rn2rob_pc;
  logic [AREG_W-1:0] rn2rob_rd;
  logic              rn2rob_rd_write;
  logic [PREG_W-1:0] rn2rob_rd_p_old;
  logic [PREG_W-1:0] rn2rob_rd_p_new;
  logic              rob2rn_ready;
  logic [TAG_W-1:0]  rob2rn_tag;

  logic              ex2rob_valid;
  logic [TAG_W-1:0]  ex2rob_tag;
  logic              flush;

  logic              rob_commit_valid;
  logic [31:0]       rob_commit_pc;
  logic [AREG_W-1:0] rob_commit_rd;
  logic [PREG_W-1:0] rob_commit_p_new;
  logic              rob2rn_free_valid;
  logic [PREG_W-1:0] rob2rn_free_p;
  logic              rob_empty;

  modport master (
    output rn2rob_valid, rn2rob_pc, rn2rob_rd,
    output rn2rob_rd_write, rn2rob_rd_p_old,
    output rn2rob_rd_p_new,
    output ex2rob_valid, ex2rob_tag, flush,
    input  rob2rn_ready, rob2rn_tag,
    input  rob_commit_valid, rob_commit_pc,
    input  rob_commit_rd, rob_commit_p_new,
    input  rob2rn_free_valid, rob2rn_free_p,
    input  rob_empty
  );

  modport slave (
    input  rn2rob_valid, rn2rob_pc, rn2rob_rd,
    input  rn2rob_rd_write, rn2rob_rd_p_old,
    input  rn2rob_rd_p_new,
    input  ex2rob_valid, ex2rob_tag, flush,
    output rob2rn_ready, rob2rn_tag,
    output rob_commit_valid, rob_commit_pc,
    output rob_commit_rd, rob_commit_p_new,
    output rob2rn_free_valid, rob2rn_free_p,
    output rob_empty
  );

endinterface

// File: rtl/rob_core.sv
// In-order retire reorder buffer: alloc at tail, complete by tag, retire at head.
// Ports: clk, rst (async high), bus (rob_if.slave) carrying all handshakes.
module rob_core
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
  parameter int ROB_TAG_W = rob_pkg::ROB_TAG_W
) (
  input logic   clk,
  input logic   rst,
  rob_if.slave  bus
);

  localparam int CNT_W = ROB_TAG_W + 1;
  localparam logic [ROB_TAG_W-1:0] LAST =
    ROB_TAG_W'(ROB_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(ROB_DEPTH);

  function automatic logic [ROB_TAG_W-1:0] nxt(
    input logic [ROB_TAG_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  rob_entry_t ent_q [ROB_DEPTH];
  rob_entry_t ent_d [ROB_DEPTH];

  logic [ROB_TAG_W-1:0] head_q, head_d;
  logic [ROB_TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic              cv_q, cv_d;
  logic [31:0]       cpc_q, cpc_d;
  logic [AREG_W-1:0] crd_q, crd_d;
  logic [PREG_W-1:0] cpn_q, cpn_d;
  logic              fv_q, fv_d;
  logic [PREG_W-1:0] fp_q, fp_d;

  logic ready;
  logic alloc;
  logic retire;

  assign ready = (count_q != FULL);

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cv_d    = 1'b0;
    cpc_d   = cpc_q;
    crd_d   = crd_q;
    cpn_d   = cpn_q;
    fv_d    = 1'b0;
    fp_d    = fp_q;
    alloc   = bus.rn2rob_valid && ready && !bus.flush;
    // An empty ROB has an invalid head, so this never fires at count 0.
    retire  = ent_q[head_q].valid && ent_q[head_q].done
              && !bus.flush;
    if (bus.flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      cpc_d   = '0;
      crd_d   = '0;
      cpn_d   = '0;
      fp_d    = '0;
    end else begin
      if (bus.ex2rob_valid && ent_q[bus.ex2rob_tag].valid)
        ent_d[bus.ex2rob_tag].done = 1'b1;
      if (retire) begin
        ent_d[head_q].valid = 1'b0;
        ent_d[head_q].done  = 1'b0;
        head_d = nxt(head_q);
        cv_d   = 1'b1;
        cpc_d  = ent_q[head_q].pc;
        crd_d  = ent_q[head_q].rd;
        cpn_d  = ent_q[head_q].p_new;
        fv_d   = ent_q[head_q].rd_write
                 && (ent_q[head_q].rd != '0);
        fp_d   = ent_q[head_q].p_old;
      end
      // Applied last: a same-index completion hit an invalid
      // entry, so the fresh allocation (done=0) stands.
      if (alloc) begin
        ent_d[tail_q].valid    = 1'b1;
        ent_d[tail_q].done     = 1'b0;
        ent_d[tail_q].pc       = bus.rn2rob_pc;
        ent_d[tail_q].rd       = bus.rn2rob_rd;
        ent_d[tail_q].rd_write = bus.rn2rob_rd_write;
        ent_d[tail_q].p_old    = bus.rn2rob_rd_p_old;
        ent_d[tail_q].p_new    = bus.rn2rob_rd_p_new;
        tail_d = nxt(tail_q);
      end
      unique case ({alloc, retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      cpc_q   <= '0;
      crd_q   <= '0;
      cpn_q   <= '0;
      fv_q    <= 1'b0;
      fp_q    <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      cpc_q   <= cpc_d;
      crd_q   <= crd_d;
      cpn_q   <= cpn_d;
      fv_q    <= fv_d;
      fp_q    <= fp_d;
    end
  end

  assign bus.rob2rn_ready      = ready;
  assign bus.rob2rn_tag        = tail_q;
  assign bus.rob_empty         = (count_q == '0);
  assign bus.rob_commit_valid  = cv_q;
  assign bus.rob_commit_pc     = cpc_q;
  assign bus.rob_commit_rd     = crd_q;
  assign bus.rob_commit_p_new  = cpn_q;
  assign bus.rob2rn_free_valid = fv_q;
  assign bus.rob2rn_free_p     = fp_q;

endmodule
